// File: rtl/wb_regfile.sv
// EX/WB pipeline register feeding a 2**AW x DW register file with two
// combinational read ports that bypass both the EX result and the EX/WB stage.
module wb_regfile #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic [AW-1:0] ex_wd_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic          ex_wreg_i,
    input  logic          re1_i,
    input  logic [AW-1:0] raddr1_i,
    output logic [DW-1:0] rdata1_o,
    input  logic          re2_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata2_o,
    output logic [AW-1:0] wb_wd_o,
    output logic [DW-1:0] wb_wdata_o,
    output logic          wb_wreg_o
);

    localparam int NREGS = 2 ** AW;

    logic [AW-1:0] wb_wd_q,    wb_wd_d;
    logic [DW-1:0] wb_wdata_q, wb_wdata_d;
    logic          wb_wreg_q,  wb_wreg_d;

    logic [DW-1:0] regs_q [NREGS];

    logic          re_v    [2];
    logic [AW-1:0] raddr_v [2];
    logic [DW-1:0] rdata_v [2];

    // Flush inserts a bubble and takes priority over stall.
    always_comb begin
        wb_wd_d    = wb_wd_q;
        wb_wdata_d = wb_wdata_q;
        wb_wreg_d  = wb_wreg_q;
        if (flush) begin
            wb_wd_d    = '0;
            wb_wdata_d = '0;
            wb_wreg_d  = 1'b0;
        end else if (!stall) begin
            wb_wd_d    = ex_wd_i;
            wb_wdata_d = ex_wdata_i;
            wb_wreg_d  = ex_wreg_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wd_q    <= '0;
            wb_wdata_q <= '0;
            wb_wreg_q  <= 1'b0;
        end else begin
            wb_wd_q    <= wb_wd_d;
            wb_wdata_q <= wb_wdata_d;
            wb_wreg_q  <= wb_wreg_d;
        end
    end

    // Entry 0 is never written so it always reads back as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_wreg_q && (wb_wd_q != '0)) begin
            regs_q[wb_wd_q] <= wb_wdata_q;
        end
    end

    assign re_v[0]    = re1_i;
    assign re_v[1]    = re2_i;
    assign raddr_v[0] = raddr1_i;
    assign raddr_v[1] = raddr2_i;

    // The EX result is younger than the EX/WB entry, so it is checked first.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata_v[p] = '0;
            if (rst || !re_v[p] || (raddr_v[p] == '0)) begin
                rdata_v[p] = '0;
            end else if (ex_wreg_i && !flush && (ex_wd_i == raddr_v[p])) begin
                rdata_v[p] = ex_wdata_i;
            end else if (wb_wreg_q && (wb_wd_q == raddr_v[p])) begin
                rdata_v[p] = wb_wdata_q;
            end else begin
                rdata_v[p] = regs_q[raddr_v[p]];
            end
        end
    end

    assign rdata1_o   = rdata_v[0];
    assign rdata2_o   = rdata_v[1];
    assign wb_wd_o    = wb_wd_q;
    assign wb_wdata_o = wb_wdata_q;
    assign wb_wreg_o  = wb_wreg_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: bypass priority, register 0, stall/flush and reset.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [4:0]  ex_wd_i;
    logic [31:0] ex_wdata_i;
    logic        ex_wreg_i;
    logic        re1_i, re2_i;
    logic [4:0]  raddr1_i, raddr2_i;
    logic [31:0] rdata1_o, rdata2_o;
    logic [4:0]  wb_wd_o;
    logic [31:0] wb_wdata_o;
    logic        wb_wreg_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_regfile #(.DW(32), .AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .ex_wd_i    (ex_wd_i),
        .ex_wdata_i (ex_wdata_i),
        .ex_wreg_i  (ex_wreg_i),
        .re1_i      (re1_i),
        .raddr1_i   (raddr1_i),
        .rdata1_o   (rdata1_o),
        .re2_i      (re2_i),
        .raddr2_i   (raddr2_i),
        .rdata2_o   (rdata2_o),
        .wb_wd_o    (wb_wd_o),
        .wb_wdata_o (wb_wdata_o),
        .wb_wreg_o  (wb_wreg_o)
    );

    task automatic applyStimulus(input logic [4:0] wd, input logic [31:0] wdata, input logic wreg);
        ex_wd_i    = wd;
        ex_wdata_i = wdata;
        ex_wreg_i  = wreg;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkWb(input string tag, input logic [4:0] wd, input logic [31:0] wdata, input logic wreg);
        checkOutput({tag, "_wd"},    {27'd0, wb_wd_o},   {27'd0, wd});
        checkOutput({tag, "_wdata"}, wb_wdata_o,         wdata);
        checkOutput({tag, "_wreg"},  {31'd0, wb_wreg_o}, {31'd0, wreg});
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        re1_i = 1'b1; raddr1_i = 5'd5; re2_i = 1'b0; raddr2_i = 5'd0;
        applyStimulus(5'd0, 32'd0, 1'b0);

        // Reset then read
        tick();
        tick();
        checkWb("rst_hold", 5'd0, 32'd0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("rst_read5", rdata1_o, 32'd0);
        checkWb("rst_rel", 5'd0, 32'd0, 1'b0);

        // Write / commit / read through EX bypass, WB bypass, then array
        raddr1_i = 5'd3; re2_i = 1'b0; raddr2_i = 5'd3;
        applyStimulus(5'd3, 32'h1234_5678, 1'b1);
        checkOutput("wr_ex_byp", rdata1_o, 32'h1234_5678);
        checkOutput("wr_re2_off", rdata2_o, 32'd0);
        tick();
        applyStimulus(5'd3, 32'h1234_5678, 1'b0);
        checkWb("wr_cap", 5'd3, 32'h1234_5678, 1'b1);
        checkOutput("wr_wb_byp", rdata1_o, 32'h1234_5678);
        tick();
        checkOutput("wr_wb_idle", {31'd0, wb_wreg_o}, 32'd0);
        checkOutput("wr_array", rdata1_o, 32'h1234_5678);
        tick();
        checkOutput("wr_array2", rdata1_o, 32'h1234_5678);

        // Register 0 is never writable
        raddr1_i = 5'd0; re2_i = 1'b1; raddr2_i = 5'd0;
        applyStimulus(5'd0, 32'hFFFF_FFFF, 1'b1);
        checkOutput("r0_ex", rdata1_o, 32'd0);
        checkOutput("r0_ex_p2", rdata2_o, 32'd0);
        tick();
        applyStimulus(5'd0, 32'hFFFF_FFFF, 1'b0);
        checkWb("r0_cap", 5'd0, 32'hFFFF_FFFF, 1'b1);
        checkOutput("r0_wb", rdata1_o, 32'd0);
        tick();
        checkOutput("r0_array", rdata1_o, 32'd0);

        // Bypass priority: array 0xA, WB 0xB, EX 0xC on register 7
        raddr1_i = 5'd7; raddr2_i = 5'd7;
        applyStimulus(5'd7, 32'hA, 1'b1);
        tick();
        applyStimulus(5'd7, 32'hB, 1'b1);
        tick();
        applyStimulus(5'd7, 32'hC, 1'b1);
        checkWb("bp_wb", 5'd7, 32'hB, 1'b1);
        checkOutput("bp_ex_p1", rdata1_o, 32'hC);
        checkOutput("bp_ex_p2", rdata2_o, 32'hC);
        applyStimulus(5'd7, 32'hC, 1'b0);
        checkOutput("bp_wb_p1", rdata1_o, 32'hB);
        checkOutput("bp_wb_p2", rdata2_o, 32'hB);
        tick();
        checkOutput("bp_array_p1", rdata1_o, 32'hB);
        checkOutput("bp_array_p2", rdata2_o, 32'hB);

        // Same-address EX and WB writes: EX data ends up in the array
        raddr1_i = 5'd10; raddr2_i = 5'd10;
        applyStimulus(5'd10, 32'h100, 1'b1);
        tick();
        applyStimulus(5'd10, 32'h200, 1'b1);
        checkOutput("dual_ex", rdata1_o, 32'h200);
        tick();
        applyStimulus(5'd10, 32'h200, 1'b0);
        tick();
        checkOutput("dual_final", rdata2_o, 32'h200);

        // Stall holds the EX/WB entry, flush clears it
        applyStimulus(5'd4, 32'h44, 1'b1);
        tick();
        applyStimulus(5'd8, 32'h66, 1'b1);
        tick();
        checkWb("st_pre", 5'd8, 32'h66, 1'b1);
        stall = 1'b1;
        applyStimulus(5'd9, 32'h55, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkWb("st_hold", 5'd8, 32'h66, 1'b1);
        end
        raddr1_i = 5'd8; raddr2_i = 5'd9;
        applyStimulus(5'd2, 32'h0, 1'b0);
        checkOutput("st_r8", rdata1_o, 32'h66);
        checkOutput("st_r9", rdata2_o, 32'd0);
        flush = 1'b1;
        tick();
        checkWb("fl_stall", 5'd0, 32'd0, 1'b0);
        stall = 1'b0;
        raddr1_i = 5'd4; raddr2_i = 5'd8;
        applyStimulus(5'd4, 32'h77, 1'b1);
        checkOutput("fl_nobyp", rdata1_o, 32'h44);
        checkOutput("fl_r8", rdata2_o, 32'h66);
        tick();
        checkWb("fl_cap", 5'd0, 32'd0, 1'b0);
        checkOutput("fl_r4_after", rdata1_o, 32'h44);
        flush = 1'b0;

        // Reset mid-operation loses the pending write
        raddr1_i = 5'd6; raddr2_i = 5'd3;
        applyStimulus(5'd6, 32'h99, 1'b1);
        tick();
        checkWb("mr_pre", 5'd6, 32'h99, 1'b1);
        rst = 1'b1;
        applyStimulus(5'd6, 32'h99, 1'b0);
        checkOutput("mr_rst_read", rdata1_o, 32'd0);
        tick();
        checkWb("mr_wb", 5'd0, 32'd0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("mr_r6", rdata1_o, 32'd0);
        checkOutput("mr_r3", rdata2_o, 32'd0);
        tick();
        checkOutput("mr_r6_late", rdata1_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
